// File: rtl/restador_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package restador_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned RESTADOR_N_DEF = 4;

endpackage

// File: rtl/restador_completo_1_bit.sv
// 1-bit full-subtractor cell: d = x - y - b_in, with borrow out.
module restador_completo_1_bit (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/restador_serie_ctrl.sv
// Bit-serial N-bit subtractor (d = x - y - b_in), LSB-first through one 1-bit cell.
// Define RESTADOR_OVF_EN to add the registered signed-overflow output ovf.
module restador_serie_ctrl
  import restador_pkg::*;
#(
  parameter int unsigned N = RESTADOR_N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
`ifdef RESTADOR_OVF_EN
  output logic         ovf,
`endif
  output logic         b_out
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  xs_q, ys_q, d_q;
  logic          brw_q, b_out_q;
  logic          cell_d, cell_b;
  logic          last;

`ifdef RESTADOR_OVF_EN
  logic sx_q, sy_q, ovf_q;
`endif

  restador_completo_1_bit u_cell (
    .x     (xs_q[0]),
    .y     (ys_q[0]),
    .b_in  (brw_q),
    .d     (cell_d),
    .b_out (cell_b)
  );

  assign last = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      b_out_q <= 1'b0;
`ifdef RESTADOR_OVF_EN
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            xs_q  <= x;
            ys_q  <= y;
            brw_q <= b_in;
            cnt_q <= '0;
            d_q   <= '0;
`ifdef RESTADOR_OVF_EN
            sx_q  <= x[N-1];
            sy_q  <= y[N-1];
`endif
          end
        end
        ST_SHIFT: begin
          xs_q  <= xs_q >> 1;
          ys_q  <= ys_q >> 1;
          d_q   <= {cell_d, d_q[N-1:1]};
          brw_q <= cell_b;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            b_out_q <= cell_b;
`ifdef RESTADOR_OVF_EN
            // The final diff bit is the result sign, so overflow is ready with done.
            ovf_q   <= (sx_q ^ sy_q) & (sx_q ^ cell_d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign d     = d_q;
  assign b_out = b_out_q;
`ifdef RESTADOR_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_restador_serie_ctrl.sv
// Self-checking bench for restador_serie_ctrl (N=4) against an arithmetic reference model.
module tb_restador_serie_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start, b_in;
  logic [N-1:0] x, y;
  logic         busy, done, b_out;
  logic [N-1:0] d;
`ifdef RESTADOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  restador_serie_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
`ifdef RESTADOR_OVF_EN
    .ovf   (ovf),
`endif
    .b_out (b_out)
  );

  always #50 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] exp_d(int a, int b, int c);
    int r;
    r = a - b - c;
    if (r < 0) r += (1 << N);
    return r[N-1:0];
  endfunction

  function automatic logic exp_bo(int a, int b, int c);
    return a < (b + c);
  endfunction

  function automatic logic exp_ovf(int a, int b, int c);
    int sa, sb, r;
    sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    r  = sa - sb - c;
    return (r < -(1 << (N - 1))) || (r > (1 << (N - 1)) - 1);
  endfunction

  // Drives one accepted start from IDLE; returns the edge count until done (-1 on timeout).
  task automatic run_op(input logic [N-1:0] ox, input logic [N-1:0] oy, input logic ob,
                        output int lat);
    start = 1'b1; x = ox; y = oy; b_in = ob;
    step();
    start = 1'b0; x = N'($urandom); y = N'($urandom); b_in = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 3 * N; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, d, b_out} !== '0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b d=%h b_out=%b want all 0", busy, done, d, b_out);
    end
`ifdef RESTADOR_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b want=0", ovf);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_vectors();
    int vx[3] = '{5, 3, 0};
    int vy[3] = '{3, 5, 0};
    int vb[3] = '{0, 0, 1};
    int vd[3] = '{2, 14, 15};
    int vo[3] = '{0, 1, 1};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(N'(vx[k]), N'(vy[k]), 1'(vb[k]), lat);
      checks++;
      if (lat !== N) begin
        failures++;
        $display("FAIL vec%0d_latency got=%0d want=%0d", k, lat, N);
      end
      checks++;
      if (d !== N'(vd[k])) begin
        failures++;
        $display("FAIL vec%0d_d got=%h want=%h", k, d, N'(vd[k]));
      end
      checks++;
      if (b_out !== 1'(vo[k])) begin
        failures++;
        $display("FAIL vec%0d_b_out got=%b want=%b", k, b_out, vo[k]);
      end
      step();
      if (k == 1) begin
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({d, b_out, done, busy} !== {4'b1110, 1'b1, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL hold d=%h b_out=%b done=%b busy=%b want e 1 0 0", d, b_out, done, busy);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1'b1; x = 4'd5; y = 4'd3; b_in = 1'b0;
    step();
    x = 4'd15; y = 4'd0;
    step();
    step();
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 3 * N; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      step();
    end
    checks++;
    if (lat < 0 || d !== 4'b0010 || b_out !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start lat=%0d d=%h b_out=%b want d=2 b_out=0", lat, d, b_out);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_no_requeue busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat, seen;
    start = 1'b1; x = 4'd5; y = 4'd3; b_in = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done, d} !== '0) begin
      failures++;
      $display("FAIL abort busy=%b done=%b d=%h want 0 0 0", busy, done, d);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 * N; i++) begin
      step();
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d busy/done cycles want=0", seen);
    end
    run_op(4'd9, 4'd4, 1'b1, lat);
    checks++;
    if (lat !== N || d !== 4'd4 || b_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_next lat=%0d d=%h b_out=%b want %0d 4 0", lat, d, b_out, N);
    end
    step();
  endtask

`ifdef RESTADOR_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(4'b1000, 4'd1, 1'b0, lat);
    checks++;
    if (d !== 4'b0111 || ovf !== 1'b1 || b_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_set d=%h ovf=%b b_out=%b want 7 1 0", d, ovf, b_out);
    end
    step();
    run_op(4'd2, 4'd1, 1'b0, lat);
    checks++;
    if (ovf !== 1'b0 || d !== 4'd1) begin
      failures++;
      $display("FAIL ovf_clear d=%h ovf=%b want 1 0", d, ovf);
    end
    step();
  endtask
`endif

  task automatic test_exhaustive();
    int lat, bad;
    bad = 0;
    for (int a = 0; a < (1 << N); a++)
      for (int b = 0; b < (1 << N); b++)
        for (int c = 0; c < 2; c++) begin
          run_op(N'(a), N'(b), 1'(c), lat);
          checks++;
          if (lat !== N || d !== exp_d(a, b, c) || b_out !== exp_bo(a, b, c)) begin
            failures++;
            bad++;
            if (bad <= 10)
              $display("FAIL sweep x=%0d y=%0d b=%0d lat=%0d d=%h b_out=%b want d=%h b_out=%b",
                       a, b, c, lat, d, b_out, exp_d(a, b, c), exp_bo(a, b, c));
          end
`ifdef RESTADOR_OVF_EN
          checks++;
          if (ovf !== exp_ovf(a, b, c)) begin
            failures++;
            bad++;
            if (bad <= 10)
              $display("FAIL sweep_ovf x=%0d y=%0d b=%0d got=%b want=%b",
                       a, b, c, ovf, exp_ovf(a, b, c));
          end
`endif
          step();
        end
  endtask

  // start held high with operands changing every cycle: only IDLE-cycle values may be used.
  task automatic test_back_to_back();
    int qx[$], qy[$], qb[$];
    int prev, ex, ey, eb;
    logic busy_now;
    prev = -1;
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (done) begin
        ex = qx.pop_front(); ey = qy.pop_front(); eb = qb.pop_front();
        checks++;
        if (d !== exp_d(ex, ey, eb) || b_out !== exp_bo(ex, ey, eb)) begin
          failures++;
          $display("FAIL b2b x=%0d y=%0d b=%0d d=%h b_out=%b want d=%h b_out=%b",
                   ex, ey, eb, d, b_out, exp_d(ex, ey, eb), exp_bo(ex, ey, eb));
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev !== N + 2) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d want=%0d", cyc - prev, N + 2);
          end
        end
        prev = cyc;
      end
      busy_now = busy;
      start = 1'b1;
      x = N'($urandom); y = N'($urandom); b_in = 1'($urandom);
      if (!busy_now) begin
        qx.push_back(int'(x)); qy.push_back(int'(y)); qb.push_back(int'(b_in));
      end
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      if (done && qx.size() > 0) begin
        ex = qx.pop_front(); ey = qy.pop_front(); eb = qb.pop_front();
        checks++;
        if (d !== exp_d(ex, ey, eb) || b_out !== exp_bo(ex, ey, eb)) begin
          failures++;
          $display("FAIL b2b_drain d=%h b_out=%b want d=%h b_out=%b",
                   d, b_out, exp_d(ex, ey, eb), exp_bo(ex, ey, eb));
        end
      end
      step();
    end
    checks++;
    if (qx.size() !== 0 || prev < 0) begin
      failures++;
      $display("FAIL b2b_completion pending=%0d first_done=%0d want 0 pending", qx.size(), prev);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    #1;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_reset_abort();
`ifdef RESTADOR_OVF_EN
    test_ovf();
`endif
    test_exhaustive();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
